issue_hazard_ctrl: RTL

//  Issue controller between decode and execute of the 5-stage RV32I pipeline. Holds a

---
 rtl/issue_hazard_ctrl.sv | 108 ++++++++++
 1 files changed

// File: rtl/issue_hazard_ctrl.sv
// Decode->execute issue controller: register scoreboard for RAW/WAW stalls, in-flight limit,
// and serialisation of control transfers with a one-cycle fetch flush on taken redirects.
module issue_hazard_ctrl #(
  parameter int unsigned MAX_INFLIGHT = 4,
  parameter bit          WB_BYPASS    = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       id_valid,
  output logic       id_ready,
  input  logic [4:0] id_rs1_idx,
  input  logic [4:0] id_rs2_idx,
  input  logic [4:0] id_rd_idx,
  input  logic       id_uses_rs1,
  input  logic       id_uses_rs2,
  input  logic       id_writes_rd,
  input  logic       id_is_xfer,
  output logic       ex_valid,
  input  logic       ex_ready,
  input  logic       wb_valid,
  input  logic [4:0] wb_rd_idx,
  input  logic       rslv_valid,
  input  logic       rslv_taken,
  output logic       if_flush,
  output logic [3:0] inflight_cnt
);

  localparam logic [3:0] MaxCnt = 4'(MAX_INFLIGHT);

  typedef enum logic [1:0] {StRun, StBrWait, StFlush} state_e;

  state_e      state_q, state_d;
  logic [31:0] sb_q, sb_d;
  logic [3:0]  cnt_q, cnt_d;

  logic [31:0] bypass_mask;
  logic [31:0] pend_vec;
  logic        wb_clr;
  logic        sb_set;
  logic        full;
  logic        hazard;
  logic        fire;

  // Only a writeback that retires a genuinely pending register affects state.
  assign wb_clr      = wb_valid & (wb_rd_idx != 5'd0) & sb_q[wb_rd_idx];
  assign bypass_mask = (WB_BYPASS && wb_valid) ? (32'd1 << wb_rd_idx) : 32'd0;
  assign pend_vec    = sb_q & ~bypass_mask;

  assign full   = (cnt_q == MaxCnt) & ~wb_clr;
  assign hazard = (id_uses_rs1  & (id_rs1_idx != 5'd0) & pend_vec[id_rs1_idx]) |
                  (id_uses_rs2  & (id_rs2_idx != 5'd0) & pend_vec[id_rs2_idx]) |
                  (id_writes_rd & (id_rd_idx  != 5'd0) & pend_vec[id_rd_idx])  |
                  full;

  assign ex_valid     = rst_n & id_valid & (state_q == StRun) & ~hazard;
  assign fire         = ex_valid & ex_ready;
  assign id_ready     = fire;
  assign if_flush     = (state_q == StFlush);
  assign inflight_cnt = cnt_q;

  assign sb_set = fire & id_writes_rd & (id_rd_idx != 5'd0);

  always_comb begin
    sb_d = sb_q;
    // Clear before set: with bypass a new write to the retiring register stays pending.
    if (wb_clr) sb_d[wb_rd_idx] = 1'b0;
    if (sb_set) sb_d[id_rd_idx] = 1'b1;
    sb_d[0] = 1'b0;
  end

  always_comb begin
    cnt_d = cnt_q;
    unique case ({sb_set, wb_clr})
      2'b10:   cnt_d = cnt_q + 4'd1;
      2'b01:   cnt_d = cnt_q - 4'd1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StRun: begin
        if (fire && id_is_xfer) state_d = StBrWait;
      end
      StBrWait: begin
        if (rslv_valid) state_d = rslv_taken ? StFlush : StRun;
      end
      StFlush: begin
        state_d = StRun;
      end
      default: state_d = StRun;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StRun;
      sb_q    <= 32'd0;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      sb_q    <= sb_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule
